// File: rtl/hsi_band_packer_if.sv
// Stream and FIFO-write bundle for hsi_band_packer: component beats in, packed vector words out.
// The packer takes the slave modport; the producer/FIFO side takes master.
interface hsi_band_packer_if #(
  parameter int COMPONENT_WIDTH = 16,
  parameter int COMPONENTS_MAX  = 200
);
  logic                                  s_valid;
  logic [COMPONENT_WIDTH-1:0]            s_data;
  logic                                  s_last;
  logic                                  s_ready;
  logic                                  out_wr_en;
  logic [COMPONENT_WIDTH*COMPONENTS_MAX-1:0] out_data;
  logic                                  out_full;

  modport master (
    output s_valid, s_data, s_last, out_full,
    input  s_ready, out_wr_en, out_data
  );

  modport slave (
    input  s_valid, s_data, s_last, out_full,
    output s_ready, out_wr_en, out_data
  );
endinterface

// File: rtl/hsi_band_packer.sv
// Packs num_bands band-serial components into one zero-filled vector word and writes it to a FIFO.
// Latency: final beat at edge N -> out_wr_en in cycle N+1 (FIFO not full); one vector per nb_q+1 cycles peak.
// Backpressure: s_ready drops while a vector waits to be written; out_full stalls the write indefinitely.
// Optional framing checks on s_last in COLLECT: define HSI_PACKER_LAST_CHECK_EN.
module hsi_band_packer #(
  parameter int COMPONENT_WIDTH = 16,
  parameter int COMPONENTS_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      num_bands,
  hsi_band_packer_if.slave bus,
  output logic [31:0]      vec_count,
  output logic             busy,
  output logic [3:0]       error_code
);

  localparam int IW = $clog2(COMPONENTS_MAX + 1);
  localparam int DW = COMPONENT_WIDTH * COMPONENTS_MAX;

  localparam logic [3:0] ERR_OK      = 4'd0;
  localparam logic [3:0] ERR_BANDS   = 4'd4;
`ifdef HSI_PACKER_LAST_CHECK_EN
  localparam logic [3:0] ERR_FRAMING = 4'd5;
`endif

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [31:0]     nb_q;
  logic [DW-1:0]   buffer;
  logic            s_ready_q;
`ifdef HSI_PACKER_LAST_CHECK_EN
  logic            drop_after;
`endif

  logic            beat;
  logic [31:0]     nb_eff;
  logic            bands_bad;
  logic            last_slot;
  logic            wr_fire;

  // Band 0 sees num_bands directly since nb_q only updates on that same edge.
  assign beat      = bus.s_valid && s_ready_q;
  assign nb_eff    = (idx == '0) ? num_bands : nb_q;
  assign bands_bad = (num_bands == 32'd0) || (num_bands > 32'(COMPONENTS_MAX));
  assign last_slot = (32'(idx) + 32'd1) == nb_eff;
  assign wr_fire   = (state == WRITE) && !bus.out_full;

  assign bus.s_ready   = s_ready_q;
  assign bus.out_wr_en = wr_fire;
  assign bus.out_data  = buffer;
  assign busy          = (idx != '0) || (state != COLLECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      idx        <= '0;
      nb_q       <= 32'd0;
      buffer     <= '0;
      s_ready_q  <= 1'b0;
      vec_count  <= 32'd0;
      error_code <= ERR_OK;
`ifdef HSI_PACKER_LAST_CHECK_EN
      drop_after <= 1'b0;
`endif
    end else begin
      error_code <= ERR_OK;
      s_ready_q  <= 1'b1;
      case (state)
        COLLECT: begin
          if (beat) begin
            if (idx == '0) begin
              nb_q <= num_bands;
            end
            if ((idx == '0) && bands_bad) begin
              error_code <= ERR_BANDS;
              if (!bus.s_last) begin
                state <= DROP;
              end
`ifdef HSI_PACKER_LAST_CHECK_EN
            end else if (bus.s_last && !last_slot) begin
              error_code <= ERR_FRAMING;
              buffer     <= '0;
              idx        <= '0;
`endif
            end else begin
              buffer[int'(idx)*COMPONENT_WIDTH +: COMPONENT_WIDTH] <= bus.s_data;
              idx <= idx + 1'b1;
              if (last_slot) begin
                state     <= WRITE;
                s_ready_q <= 1'b0;
`ifdef HSI_PACKER_LAST_CHECK_EN
                if (!bus.s_last) begin
                  error_code <= ERR_FRAMING;
                  drop_after <= 1'b1;
                end
`endif
              end
            end
          end
        end

        WRITE: begin
          s_ready_q <= wr_fire;
          if (wr_fire) begin
            vec_count <= vec_count + 32'd1;
            buffer    <= '0;
            idx       <= '0;
`ifdef HSI_PACKER_LAST_CHECK_EN
            state      <= drop_after ? DROP : COLLECT;
            drop_after <= 1'b0;
`else
            state <= COLLECT;
`endif
          end
        end

        DROP: begin
          if (beat && bus.s_last) begin
            state <= COLLECT;
            idx   <= '0;
          end
        end

        default: begin
          state <= COLLECT;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsi_band_packer.sv
// Scoreboard bench for hsi_band_packer: expected words queued at stimulus, checked on each FIFO write.
module tb_hsi_band_packer;
  localparam int CW = 16;
  localparam int CM = 200;
  localparam int DW = CW * CM;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] num_bands = 32'd0;
  logic [31:0] vec_count;
  logic        busy;
  logic [3:0]  error_code;

  hsi_band_packer_if #(.COMPONENT_WIDTH(CW), .COMPONENTS_MAX(CM)) bus();

  hsi_band_packer #(.COMPONENT_WIDTH(CW), .COMPONENTS_MAX(CM)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .num_bands  (num_bands),
    .bus        (bus),
    .vec_count  (vec_count),
    .busy       (busy),
    .error_code (error_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  int mon_slot;
  int wr_cnt = 0;
  int wr_cyc = -1;
  int err4_cnt = 0;
  int err5_cnt = 0;
  int last_beat_cyc = 0;
  int exp_vc = 0;

  function automatic int first_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int i = 0; i < CM; i++)
      if (a[i*CW +: CW] !== b[i*CW +: CW]) return i;
    return 0;
  endfunction

  // Write monitor: pops the scoreboard on every strobe and tallies error pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (error_code == 4'd4) err4_cnt++;
      else if (error_code == 4'd5) err5_cnt++;
      else if (error_code !== 4'd0) begin
        n_checks++; n_fail++;
        $display("FAIL error_code_value: got %0d required 0/4/5", error_code);
      end
      if (bus.out_wr_en === 1'b1) begin
        wr_cnt++;
        wr_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got write at cycle %0d, required none", cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.out_data !== mon_exp) begin
            mon_slot = first_diff(bus.out_data, mon_exp);
            n_fail++;
            $display("FAIL write_data: slot %0d got %h required %h", mon_slot,
                     bus.out_data[mon_slot*CW +: CW], mon_exp[mon_slot*CW +: CW]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [CW-1:0] d, input logic last);
    bit acc = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
    for (int t = 0; t < 60; t++) begin
      acc = (bus.s_ready === 1'b1);
      tick();
      if (acc) begin
        last_beat_cyc = cyc;
        break;
      end
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL beat_accept: got s_ready=0 for 60 cycles, required 1");
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  // Sends slots 0..nb-1 of word; num_bands is scrambled after band 0 since it must be ignored then.
  task automatic send_vec(input int nb, input logic [DW-1:0] word);
    logic [DW-1:0] e = '0;
    for (int i = 0; i < nb; i++) e[i*CW +: CW] = word[i*CW +: CW];
    exp_q.push_back(e);
    exp_vc++;
    num_bands = nb;
    for (int i = 0; i < nb; i++) begin
      send_beat(word[i*CW +: CW], i == nb - 1);
      if (i == 0) num_bands = $urandom;
    end
  endtask

  task automatic wait_drain(output int left);
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) tick();
    tick();
    left = exp_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.out_full = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b required 0", bus.s_ready); end
    n_checks++; if (bus.out_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b required 0", bus.out_wr_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_checks++; if (vec_count !== 32'd0) begin n_fail++; $display("FAIL rst_vec_count: got %0d required 0", vec_count); end
    n_checks++; if (error_code !== 4'd0) begin n_fail++; $display("FAIL rst_error: got %0d required 0", error_code); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got nonzero word, required 0"); end
    rst_n = 1'b1;
    tick(); tick();
    n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_s_ready: got %b required 1", bus.s_ready); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] w = '0;
    int w0 = wr_cnt;
    int left;
    w[0 +: CW] = 16'h0001; w[CW +: CW] = 16'h0002; w[2*CW +: CW] = 16'h0003;
    send_vec(3, w);
    n_checks++; if (bus.s_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_write_state: got s_ready=%b busy=%b required 0 1", bus.s_ready, busy); end
    wait_drain(left);
    n_checks++; if (left !== 0) begin n_fail++; $display("FAIL basic_drain: got %0d pending required 0", left); end
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL basic_writes: got %0d required 1", wr_cnt - w0); end
    n_checks++; if (wr_cyc !== last_beat_cyc) begin n_fail++; $display("FAIL basic_latency: got write cycle %0d required %0d", wr_cyc, last_beat_cyc); end
    n_checks++; if (vec_count !== 32'(exp_vc)) begin n_fail++; $display("FAIL basic_vec_count: got %0d required %0d", vec_count, exp_vc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b required 0", busy); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] w = '0;
    int w0 = wr_cnt;
    int left;
    w[0 +: CW] = 16'hA5A5; w[CW +: CW] = 16'h5A5A; w[2*CW +: CW] = 16'hFFFF;
    bus.out_full = 1'b1;
    send_vec(3, w);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus.s_ready !== 1'b0 || bus.out_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got s_ready=%b wr_en=%b required 0 0", k, bus.s_ready, bus.out_wr_en);
      end
      tick();
    end
    bus.out_full = 1'b0;
    wait_drain(left);
    n_checks++; if (left !== 0) begin n_fail++; $display("FAIL stall_drain: got %0d pending required 0", left); end
    n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL stall_writes: got %0d required 1", wr_cnt - w0); end
    n_checks++; if (wr_cyc !== last_beat_cyc + 5) begin n_fail++; $display("FAIL stall_release: got write cycle %0d required %0d", wr_cyc, last_beat_cyc + 5); end
  endtask

  task automatic test_bad_bands();
    logic [DW-1:0] w = '0;
    int e4 = err4_cnt;
    int w0 = wr_cnt;
    int left;
    num_bands = 32'd201;
    for (int i = 0; i < 4; i++) send_beat(16'h1000 + 16'(i), i == 3);
    tick(); tick();
    n_checks++; if (err4_cnt - e4 !== 1) begin n_fail++; $display("FAIL bands_over_err: got %0d pulses required 1", err4_cnt - e4); end
    n_checks++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL bands_over_nowrite: got %0d writes required 0", wr_cnt - w0); end
    num_bands = 32'd0;
    send_beat(16'hBEEF, 1'b1);
    tick();
    n_checks++; if (err4_cnt - e4 !== 2) begin n_fail++; $display("FAIL bands_zero_err: got %0d pulses required 2", err4_cnt - e4); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bands_zero_idle: got busy=%b required 0", busy); end
    w[0 +: CW] = 16'h00C8; w[CW +: CW] = 16'h0C80;
    send_vec(2, w);
    wait_drain(left);
    n_checks++; if (left !== 0 || wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL bands_recover: got pending=%0d writes=%0d required 0 1", left, wr_cnt - w0); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    int w0 = wr_cnt;
    int a_end;
    int left;
    a[0 +: CW] = 16'h7FFF; a[CW +: CW] = 16'h8000;
    b[0 +: CW] = 16'h1234; b[CW +: CW] = 16'hDEAD;
    send_vec(2, a);
    a_end = last_beat_cyc;
    send_vec(1, b);
    n_checks++; if (last_beat_cyc !== a_end + 2) begin n_fail++; $display("FAIL b2b_throughput: got B beat cycle %0d required %0d", last_beat_cyc, a_end + 2); end
    wait_drain(left);
    n_checks++; if (left !== 0 || wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL b2b_writes: got pending=%0d writes=%0d required 0 2", left, wr_cnt - w0); end
    n_checks++; if (vec_count !== 32'(exp_vc)) begin n_fail++; $display("FAIL b2b_vec_count: got %0d required %0d", vec_count, exp_vc); end
  endtask

  task automatic test_full_width();
    logic [DW-1:0] w;
    int left;
    for (int i = 0; i < CM; i++) w[i*CW +: CW] = CW'($urandom);
    send_vec(CM, w);
    wait_drain(left);
    n_checks++; if (left !== 0) begin n_fail++; $display("FAIL full_width_drain: got %0d pending required 0", left); end
  endtask

  task automatic test_reset_mid_vector();
    logic [DW-1:0] w = '0;
    int w0;
    int left;
    num_bands = 32'd3;
    send_beat(16'hAAAA, 1'b0);
    send_beat(16'hBBBB, 1'b0);
    rst_n = 1'b0;
    exp_vc = 0;
    #1;
    n_checks++; if (busy !== 1'b0 || vec_count !== 32'd0) begin n_fail++; $display("FAIL midrst_clear: got busy=%b vec_count=%0d required 0 0", busy, vec_count); end
    tick(); tick();
    rst_n = 1'b1;
    w0 = wr_cnt;
    tick();
    w[0 +: CW] = 16'h0101; w[CW +: CW] = 16'h0202; w[2*CW +: CW] = 16'h0303;
    send_vec(3, w);
    wait_drain(left);
    n_checks++; if (left !== 0 || wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL midrst_writes: got pending=%0d writes=%0d required 0 1", left, wr_cnt - w0); end
    n_checks++; if (vec_count !== 32'd1) begin n_fail++; $display("FAIL midrst_vec_count: got %0d required 1", vec_count); end
  endtask

  task automatic test_framing();
    logic [DW-1:0] e = '0;
    logic [DW-1:0] w = '0;
    int e5 = err5_cnt;
    int w0 = wr_cnt;
    int left;
    int exp_err5;
    int exp_wr;
    // Four beats with s_last on band 2 and again on band 3.
`ifndef HSI_PACKER_LAST_CHECK_EN
    e[0 +: CW] = 16'h0A0A; e[CW +: CW] = 16'h0B0B; e[2*CW +: CW] = 16'h0C0C; e[3*CW +: CW] = 16'h0D0D;
    exp_q.push_back(e);
`endif
    num_bands = 32'd4;
    send_beat(16'h0A0A, 1'b0);
    send_beat(16'h0B0B, 1'b0);
    send_beat(16'h0C0C, 1'b1);
    send_beat(16'h0D0D, 1'b1);
    for (int i = 0; i < 4; i++) w[i*CW +: CW] = 16'h4000 + 16'(i);
    send_vec(4, w);
    // Final band with s_last low, followed by a two-beat tail ending in s_last.
    e = '0;
    e[0 +: CW] = 16'h1111; e[CW +: CW] = 16'h2222;
    exp_q.push_back(e);
`ifndef HSI_PACKER_LAST_CHECK_EN
    e = '0;
    e[0 +: CW] = 16'h3333; e[CW +: CW] = 16'h4444;
    exp_q.push_back(e);
`endif
    num_bands = 32'd2;
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b0);
    send_beat(16'h3333, 1'b0);
    send_beat(16'h4444, 1'b1);
    wait_drain(left);
`ifdef HSI_PACKER_LAST_CHECK_EN
    exp_err5 = 3; exp_wr = 2;
`else
    exp_err5 = 0; exp_wr = 4;
`endif
    n_checks++; if (left !== 0) begin n_fail++; $display("FAIL framing_drain: got %0d pending required 0", left); end
    n_checks++; if (err5_cnt - e5 !== exp_err5) begin n_fail++; $display("FAIL framing_err: got %0d pulses required %0d", err5_cnt - e5, exp_err5); end
    n_checks++; if (wr_cnt - w0 !== exp_wr) begin n_fail++; $display("FAIL framing_writes: got %0d required %0d", wr_cnt - w0, exp_wr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL framing_idle: got busy=%b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bad_bands();
    test_back_to_back();
    test_full_width();
    test_reset_mid_vector();
    test_framing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
